cache: RTL and testbench

CACHE -- requirements
Module: cache

---
 rtl/cache.sv | 131 +++++++++++++
 tb/tb_cache.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/cache.sv
// Direct-mapped, write-through/write-allocate cache with 2-byte lines.
// Optional snoop invalidation is enabled by defining CACHE_INVALIDATE_EN.
module cache #(
  parameter int unsigned INDEX_BITS = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [24:0] cpu_request,
  input  logic        cpu_request_ready,
  input  logic [15:0] invalidate_address,
  input  logic [15:0] memory_response,
  input  logic        memory_response_ready,
  output logic [24:0] memory_request,
  output logic        memory_request_ready,
  output logic [7:0]  data_out,
  output logic        data_out_ready
);

  localparam int unsigned LINES    = 1 << INDEX_BITS;
  localparam int unsigned TAG_BITS = 15 - INDEX_BITS;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] DONE     = 2'd2;

  logic [1:0]            state;
  logic [15:0]           addr_q;
  logic [LINES-1:0]      valid;
  logic [LINES-1:0]      valid_d;
  logic [TAG_BITS-1:0]   tags  [LINES];
  logic [15:0]           lines [LINES];

  logic                  req_write;
  logic [7:0]            req_wdata;
  logic [15:0]           req_addr;
  logic [INDEX_BITS-1:0] req_index;
  logic [TAG_BITS-1:0]   req_tag;
  logic                  hit;
  logic [7:0]            hit_byte;

  logic [INDEX_BITS-1:0] fill_index;
  logic [TAG_BITS-1:0]   fill_tag;
  logic                  fill;
  logic [7:0]            resp_byte;

  assign req_write = cpu_request[24];
  assign req_wdata = cpu_request[23:16];
  assign req_addr  = cpu_request[15:0];
  assign req_index = req_addr[INDEX_BITS:1];
  assign req_tag   = req_addr[15:INDEX_BITS+1];
  assign hit       = valid[req_index] && (tags[req_index] == req_tag);
  assign hit_byte  = req_addr[0] ? lines[req_index][15:8] : lines[req_index][7:0];

  // The latched address drives the refill so later cpu_request changes are ignored.
  assign fill_index = addr_q[INDEX_BITS:1];
  assign fill_tag   = addr_q[15:INDEX_BITS+1];
  assign fill       = (state == MEM_WAIT) && memory_response_ready;
  assign resp_byte  = addr_q[0] ? memory_response[15:8] : memory_response[7:0];

  assign data_out_ready = (state == DONE);

`ifdef CACHE_INVALIDATE_EN
  logic [INDEX_BITS-1:0] inv_index;
  logic [TAG_BITS-1:0]   inv_tag;
  logic                  inv_hit;

  assign inv_index = invalidate_address[INDEX_BITS:1];
  assign inv_tag   = invalidate_address[15:INDEX_BITS+1];
  assign inv_hit   = (invalidate_address != 16'h0000) && valid[inv_index] &&
                     (tags[inv_index] == inv_tag);
`else
  logic unused_invalidate;
  assign unused_invalidate = ^invalidate_address;
`endif

  // Fill is applied after the invalidate so a same-edge collision leaves the line valid.
  always_comb begin
    valid_d = valid;
`ifdef CACHE_INVALIDATE_EN
    if (inv_hit) valid_d[inv_index] = 1'b0;
`endif
    if (fill) valid_d[fill_index] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (fill) begin
      tags[fill_index]  <= fill_tag;
      lines[fill_index] <= memory_response;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state                <= IDLE;
      valid                <= '0;
      addr_q               <= '0;
      memory_request       <= '0;
      memory_request_ready <= 1'b0;
      data_out             <= '0;
    end else begin
      valid <= valid_d;
      case (state)
        IDLE: begin
          if (cpu_request_ready) begin
            addr_q <= req_addr;
            if (!req_write && hit) begin
              data_out <= hit_byte;
              state    <= DONE;
            end else begin
              memory_request       <= {req_write, (req_write ? req_wdata : 8'h00), req_addr};
              memory_request_ready <= 1'b1;
              state                <= MEM_WAIT;
            end
          end
        end
        MEM_WAIT: begin
          if (memory_response_ready) begin
            memory_request_ready <= 1'b0;
            data_out             <= resp_byte;
            state                <= DONE;
          end
        end
        DONE: begin
          if (!cpu_request_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache.sv
// Randomized self-checking bench for cache: a line-level model plus a backing byte memory
// predict every output; directed transactions pin the model with literal expectations.
module tb_cache;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [24:0] cpu_request = '0;
  logic        cpu_request_ready = 1'b0;
  logic [15:0] invalidate_address = '0;
  logic [15:0] memory_response = '0;
  logic        memory_response_ready = 1'b0;
  logic [24:0] memory_request;
  logic        memory_request_ready;
  logic [7:0]  data_out;
  logic        data_out_ready;

  always #5 clock = ~clock;

  cache #(.INDEX_BITS(4)) dut (
    .clock                 (clock),
    .reset                 (reset),
    .cpu_request           (cpu_request),
    .cpu_request_ready     (cpu_request_ready),
    .invalidate_address    (invalidate_address),
    .memory_response       (memory_response),
    .memory_response_ready (memory_response_ready),
    .memory_request        (memory_request),
    .memory_request_ready  (memory_request_ready),
    .data_out              (data_out),
    .data_out_ready        (data_out_ready)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: which memory block each of the 16 lines holds, plus the whole backing memory.
  bit         m_valid [16];
  int         m_tag   [16];
  logic [7:0] mem     [65536];

  logic        exp_mrr  = 1'b0;
  logic        exp_dor  = 1'b0;
  logic [7:0]  exp_dout = 8'h00;
  logic [24:0] exp_mreq = '0;
  bit          live     = 1'b0;

  function automatic int idx_of(input logic [15:0] a);
    return int'((a >> 1) & 16'h000f);
  endfunction

  function automatic int tag_of(input logic [15:0] a);
    return int'(a >> 5);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (live && reset) begin
      check("memory_request_ready", 32'(memory_request_ready), 32'(exp_mrr));
      check("data_out_ready", 32'(data_out_ready), 32'(exp_dor));
      check("data_out", 32'(data_out), 32'(exp_dout));
      if (exp_mrr) check("memory_request", 32'(memory_request), 32'(exp_mreq));
    end
  end

  task automatic access(input bit wr, input logic [15:0] a, input logic [7:0] wd,
                        input int lat, input int hold, input bit inv_fill,
                        output bit saw_mreq, output logic [24:0] mreq_seen,
                        output logic [7:0] got);
    bit hit;
    hit = !wr && m_valid[idx_of(a)] && (m_tag[idx_of(a)] == tag_of(a));
    cpu_request       = {wr, wd, a};
    cpu_request_ready = 1'b1;
    @(posedge clock); #1;
    saw_mreq    = memory_request_ready;
    mreq_seen   = memory_request;
    cpu_request = 25'($urandom);
    if (hit) begin
      exp_dor  = 1'b1;
      exp_dout = mem[a];
    end else begin
      exp_mrr  = 1'b1;
      exp_mreq = {wr, (wr ? wd : 8'h00), a};
      repeat (lat) begin
        memory_response = 16'($urandom);
        @(posedge clock); #1;
      end
      if (wr) mem[a] = wd;
      memory_response       = {mem[{a[15:1], 1'b1}], mem[{a[15:1], 1'b0}]};
      memory_response_ready = 1'b1;
      if (inv_fill) invalidate_address = a;
      @(posedge clock); #1;
      memory_response_ready = 1'b0;
      invalidate_address    = 16'h0000;
      m_valid[idx_of(a)]    = 1'b1;
      m_tag[idx_of(a)]      = tag_of(a);
      exp_mrr  = 1'b0;
      exp_dor  = 1'b1;
      exp_dout = mem[a];
    end
    got = data_out;
    // Responses arriving outside MEM_WAIT must be ignored.
    repeat (hold) begin
      memory_response_ready = 1'($urandom_range(0, 1));
      memory_response       = 16'($urandom);
      @(posedge clock); #1;
    end
    memory_response_ready = 1'b0;
    cpu_request_ready     = 1'b0;
    @(posedge clock); #1;
    exp_dor = 1'b0;
  endtask

  task automatic snoop(input logic [15:0] a);
    invalidate_address = a;
    @(posedge clock); #1;
    invalidate_address = 16'h0000;
`ifdef CACHE_INVALIDATE_EN
    if (a != 16'h0000 && m_valid[idx_of(a)] && m_tag[idx_of(a)] == tag_of(a))
      m_valid[idx_of(a)] = 1'b0;
`endif
  endtask

  task automatic rd(input logic [15:0] a, output bit s, output logic [7:0] g);
    logic [24:0] mq;
    access(1'b0, a, 8'h00, 1, 0, 1'b0, s, mq, g);
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d, output bit s, output logic [7:0] g);
    logic [24:0] mq;
    access(1'b1, a, d, 1, 1, 1'b0, s, mq, g);
  endtask

  initial begin
    bit          s;
    logic [7:0]  g;
    logic [24:0] mq;

    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 0;
    end

    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    check("reset_memory_request", 32'(memory_request), 32'h0);
    check("reset_mrr", 32'(memory_request_ready), 32'h0);
    check("reset_data_out", 32'(data_out), 32'h0);
    check("reset_dor", 32'(data_out_ready), 32'h0);
    live = 1'b1;

    access(1'b1, 16'h000c, 8'h55, 2, 0, 1'b0, s, mq, g);
    check("w55_miss", 32'(s), 32'h1);
    check("w55_request", 32'(mq), 32'h155000c);
    check("w55_data", 32'(g), 32'h55);
    wr(16'h000d, 8'h56, s, g);
    check("w56_data", 32'(g), 32'h56);
    rd(16'h000c, s, g);
    check("r0c_hit", 32'(s), 32'h0);
    check("r0c_data", 32'(g), 32'h55);
    rd(16'h000d, s, g);
    check("r0d_hit", 32'(s), 32'h0);
    check("r0d_data", 32'(g), 32'h56);
    wr(16'h000d, 8'h34, s, g);
    rd(16'h000d, s, g);
    check("r0d_34_hit", 32'(s), 32'h0);
    check("r0d_34_data", 32'(g), 32'h34);
    wr(16'h000c, 8'h21, s, g);
    rd(16'h000c, s, g);
    check("r0c_21_data", 32'(g), 32'h21);
    rd(16'h000d, s, g);
    check("r0d_34b_hit", 32'(s), 32'h0);
    check("r0d_34b_data", 32'(g), 32'h34);
    rd(16'h002c, s, g);
    check("r2c_conflict_miss", 32'(s), 32'h1);
    rd(16'h000c, s, g);
    check("r0c_refetch_miss", 32'(s), 32'h1);
    check("r0c_refetch_data", 32'(g), 32'h21);

    // Invalidate colliding with the fill: the line must still be valid afterwards.
    access(1'b0, 16'h001c, 8'h00, 0, 0, 1'b1, s, mq, g);
    check("r1c_miss", 32'(s), 32'h1);
    rd(16'h001d, s, g);
    check("r1d_fill_wins_hit", 32'(s), 32'h0);

    // Reset in the middle of a miss.
    cpu_request       = {1'b0, 8'h00, 16'h0040};
    cpu_request_ready = 1'b1;
    @(posedge clock); #1;
    check("abort_mrr_before", 32'(memory_request_ready), 32'h1);
    #2 reset = 1'b0;
    exp_mrr = 1'b0; exp_dor = 1'b0; exp_dout = 8'h00;
    cpu_request_ready = 1'b0;
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    #1;
    check("abort_mrr", 32'(memory_request_ready), 32'h0);
    check("abort_mreq", 32'(memory_request), 32'h0);
    check("abort_dout", 32'(data_out), 32'h0);
    @(posedge clock); #1 reset = 1'b1;
    rd(16'h000c, s, g);
    check("post_reset_miss", 32'(s), 32'h1);
    check("post_reset_data", 32'(g), 32'h21);

    snoop(16'h000c);
    rd(16'h000d, s, g);
`ifdef CACHE_INVALIDATE_EN
    check("snoop_read_miss", 32'(s), 32'h1);
`else
    check("snoop_read_hit", 32'(s), 32'h0);
`endif
    check("snoop_read_data", 32'(g), 32'h34);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        snoop(($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom_range(0, 127)));
      end else begin
        access($urandom_range(0, 2) == 0, 16'($urandom_range(0, 127)), 8'($urandom),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
               $urandom_range(0, 15) == 0, s, mq, g);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
